frame_scheduler: RTL
====================

# frame_scheduler

Sequences double-buffer swaps and driver starts for all NeoPixel channels. It sits between the SPI frame parser's frame-complete pulse and the per-channel double buffers and drivers. A completed frame is swapped in only when every driver is idle and the WS2812 latch gap has elapsed. Frames arriving while one is already pending are coalesced. An optional periodic re-send of the current front buffer is supported.

## Interface
- `CH_NUM`, 6, number of driver channels.
- `LATCH_CYCLES`, 15000, minimum idle cycles (all busy low) before a swap or start; 300 µs at 50 MHz.
- `START_DELAY`, 2, cycles from `o_swap` to `o_start`; legal range 1..7.
- `REFRESH_CYCLES`, 0, auto re-send period in cycles measured from the last `o_start`; 0 disables.
- `RUN_TIMEOUT`, 8, cycles allowed after `o_start` for any busy to rise.

- `i_clk50m`  in  1  system clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_frame_valid`  in  1  one-cycle pulse: a new frame is complete in the back buffers.
- `i_busy`  in  `CH_NUM`  per-channel driver busy.
- `o_swap`  out  1  one-cycle pulse to all double buffers.
- `o_start`  out  1  one-cycle pulse to all drivers.
- `o_pending`  out  1  frame accepted, not yet swapped.
- `o_drop_cnt`  out  8  saturating count of coalesced frames.
- `o_state`  out  3  current state encoding, for debug LEDs.

## Operation
- Reset values: all outputs 0; state `IDLE`; pending 0. The latch counter resets saturated, so the first frame needs no gap. The refresh counter resets to 0.
- Pending flag:
  - Set by `i_frame_valid`.
  - Cleared in the `SWAP` cycle. A simultaneous `i_frame_valid` does not re-set it: the swapped buffer already holds that frame, and no drop is counted.
  - `i_frame_valid` while pending is already 1 (outside `SWAP`) increments `o_drop_cnt`, saturating at 255.
- Latch counter:
  - Clears to 0 on any cycle with `|i_busy`.
  - Otherwise increments, saturating at `LATCH_CYCLES`.
  - `gap_ok` = (counter == `LATCH_CYCLES`) && !`|i_busy`.
- Refresh counter: clears on `o_start`, otherwise increments, saturating at `REFRESH_CYCLES`. `refresh_due` = (`REFRESH_CYCLES` != 0) && (counter == `REFRESH_CYCLES`).
- State machine, encoding 0..4:
  - `IDLE`:
    - pending && `gap_ok` → `SWAP`.
    - Else !pending && `refresh_due` && `gap_ok` → `START`; this re-sends without a swap.
    - Else stay.
  - `SWAP`: `o_swap`=1; settle counter loaded with `START_DELAY`-1 → `SETTLE`.
  - `SETTLE`: count down; at 0 → `START`.
  - `START`: `o_start`=1 → `RUN`.
  - `RUN`:
    - Waits for any busy high, then for all busy low → `IDLE`.
    - If no busy rises within `RUN_TIMEOUT` cycles of entering `RUN` → `IDLE`; timeout does not count as a drop.
- Frames arriving in `SETTLE`, `START` or `RUN` only set pending; they are served after the next gap.
- Asynchronous reset mid-sequence aborts immediately. No swap or start pulse is emitted during or after reset until a new `i_frame_valid`; a refresh also waits for `REFRESH_CYCLES`.

## Timing
- Idle system with gap satisfied, `i_frame_valid` at cycle t:
  - `o_pending`=1 at t+1.
  - `o_swap` high during t+1; `o_pending` returns to 0 at t+2.
  - `o_start` high during t+1+`START_DELAY`; with the default `START_DELAY`=2, at t+3.
- After the last busy falls, the next `o_swap` or refresh `o_start` comes no earlier than `LATCH_CYCLES` cycles later.
- `o_swap` and `o_start` are never high in the same cycle and never high for more than one cycle.
- Every `o_swap` is followed by exactly one `o_start`.
- All outputs are registered.

## Structure
- Shared package `spi_led_pkg`:
  - typedef `sched_state_t` (`IDLE`, `SWAP`, `SETTLE`, `START`, `RUN`).
  - Default `LATCH_CYCLES` constant.
- One sub-module `idle_gap_timer`: the latch counter, with `i_busy_any` in and `o_gap_ok` out.
- The refresh counter and FSM stay in `frame_scheduler`.

## Test plan
- Reset release, then `i_frame_valid` at t with busy=0 → `o_swap` at t+1, `o_start` at t+3, `o_drop_cnt`=0.
- busy held high; 3 `i_frame_valid` pulses → one `o_swap` issued exactly 15000 cycles after busy falls; `o_drop_cnt`=2.
- `i_frame_valid` in `RUN` with busy high for 100 cycles → swap no earlier than 15000 cycles after busy falls; no `o_start` overlap.
- `REFRESH_CYCLES`=20000, no frames, busy=0 → `o_start` every 20001 cycles without `o_swap`.
- `o_start` with busy never rising → returns to `IDLE` after 8 cycles; state and outputs are sane.
- Assert `i_rst_n`=0 in `SETTLE` → outputs 0 immediately; no `o_start` after release.

Source files
------------

// File: rtl/spi_led_pkg.sv
// Shared types and defaults for the SPI-driven NeoPixel controller.
// Scheduler state encoding is visible on o_state, so the values are fixed.
package spi_led_pkg;

  localparam int LATCH_CYCLES_DEFAULT = 15000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SWAP   = 3'd1,
    SETTLE = 3'd2,
    START  = 3'd3,
    RUN    = 3'd4
  } sched_state_t;

  // Width of a counter that must hold 0..max_val (never narrower than 1 bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/idle_gap_timer.sv
// WS2812 latch-gap timer: counts consecutive cycles with every driver idle.
// Resets saturated so the first frame after reset is not delayed.
module idle_gap_timer
  import spi_led_pkg::*;
#(
  parameter int LATCH_CYCLES = LATCH_CYCLES_DEFAULT
) (
  input  logic i_clk50m,
  input  logic i_rst_n,
  input  logic i_busy_any,
  output logic o_gap_ok
);

  localparam int                 W   = cnt_width(LATCH_CYCLES);
  localparam logic [W-1:0]       SAT = W'(LATCH_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_busy_any) begin
      cnt_d = '0;
    end else if (cnt_q != SAT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= SAT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_gap_ok = (cnt_q == SAT) && !i_busy_any;

endmodule

// File: rtl/frame_scheduler.sv
// Sequences double-buffer swaps and driver starts across all NeoPixel channels,
// coalescing frames that arrive while one is pending and optionally re-sending.
module frame_scheduler
  import spi_led_pkg::*;
#(
  parameter int CH_NUM         = 6,
  parameter int LATCH_CYCLES   = LATCH_CYCLES_DEFAULT,
  parameter int START_DELAY    = 2,
  parameter int REFRESH_CYCLES = 0,
  parameter int RUN_TIMEOUT    = 8
) (
  input  logic              i_clk50m,
  input  logic              i_rst_n,
  input  logic              i_frame_valid,
  input  logic [CH_NUM-1:0] i_busy,
  output logic              o_swap,
  output logic              o_start,
  output logic              o_pending,
  output logic [7:0]        o_drop_cnt,
  output logic [2:0]        o_state
);

  localparam int            RW       = cnt_width(REFRESH_CYCLES);
  localparam int            TW       = cnt_width(RUN_TIMEOUT);
  localparam logic [RW-1:0] REF_SAT  = RW'(REFRESH_CYCLES);
  localparam logic [TW-1:0] RUN_LAST = TW'(RUN_TIMEOUT - 1);

  sched_state_t  state_q, state_d;
  logic          pending_q, pending_d;
  logic [7:0]    drop_q, drop_d;
  logic [2:0]    settle_q, settle_d;
  logic [TW-1:0] run_cnt_q, run_cnt_d;
  logic          seen_busy_q, seen_busy_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic          swap_q, start_q;

  logic busy_any, gap_ok, pend_now, refresh_due;

  assign busy_any    = |i_busy;
  assign pend_now    = pending_q | i_frame_valid;
  assign refresh_due = (REFRESH_CYCLES != 0) && (refresh_q == REF_SAT);

  idle_gap_timer #(
    .LATCH_CYCLES(LATCH_CYCLES)
  ) u_gap (
    .i_clk50m  (i_clk50m),
    .i_rst_n   (i_rst_n),
    .i_busy_any(busy_any),
    .o_gap_ok  (gap_ok)
  );

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    run_cnt_d   = run_cnt_q;
    seen_busy_d = seen_busy_q;
    case (state_q)
      IDLE: begin
        if (pend_now && gap_ok) begin
          state_d = SWAP;
        end else if (!pend_now && refresh_due && gap_ok) begin
          state_d = START;
        end
      end
      SWAP: begin
        // SETTLE lasts START_DELAY-1 cycles; a delay of 1 skips it entirely.
        settle_d = 3'(START_DELAY - 1);
        state_d  = (START_DELAY <= 1) ? START : SETTLE;
      end
      SETTLE: begin
        if (settle_q <= 3'd1) begin
          state_d = START;
        end else begin
          settle_d = settle_q - 3'd1;
        end
      end
      START: begin
        state_d     = RUN;
        run_cnt_d   = '0;
        seen_busy_d = 1'b0;
      end
      RUN: begin
        if (seen_busy_q) begin
          if (!busy_any) state_d = IDLE;
        end else if (busy_any) begin
          seen_busy_d = 1'b1;
        end else if (run_cnt_q == RUN_LAST) begin
          state_d = IDLE;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The swapped buffer already holds a frame arriving during SWAP, so it is neither pending nor dropped.
  always_comb begin
    pending_d = pending_q;
    drop_d    = drop_q;
    if (state_q == SWAP) begin
      pending_d = 1'b0;
    end else if (i_frame_valid) begin
      pending_d = 1'b1;
      if (pending_q && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end
  end

  always_comb begin
    refresh_d = refresh_q;
    if (state_d == START) begin
      refresh_d = '0;
    end else if (refresh_q != REF_SAT) begin
      refresh_d = refresh_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      drop_q      <= '0;
      settle_q    <= '0;
      run_cnt_q   <= '0;
      seen_busy_q <= 1'b0;
      refresh_q   <= '0;
      swap_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      drop_q      <= drop_d;
      settle_q    <= settle_d;
      run_cnt_q   <= run_cnt_d;
      seen_busy_q <= seen_busy_d;
      refresh_q   <= refresh_d;
      swap_q      <= (state_d == SWAP);
      start_q     <= (state_d == START);
    end
  end

  assign o_swap     = swap_q;
  assign o_start    = start_q;
  assign o_pending  = pending_q;
  assign o_drop_cnt = drop_q;
  assign o_state    = state_q;

endmodule
